// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
//  Module      : bin_to_bcd_seq_if
//  Description : Start/busy/done handshake and result bus for the sequential
//                binary-to-BCD converter. The blank vector exists only when
//                LEADING_ZERO_BLANK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic                  start;
    logic [WIDTH-1:0]      num;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]     blank;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, num,
        input  busy, done, bcd, overflow, blank
    );

    // Converter side
    modport slave (
        input  start, num,
        output busy, done, bcd, overflow, blank
    );
`else
    // Requester side: issues operands, observes status and result
    modport master (
        output start, num,
        input  busy, done, bcd, overflow
    );

    // Converter side
    modport slave (
        input  start, num,
        output busy, done, bcd, overflow
    );
`endif
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential binary-to-BCD converter (double dabble), one bit
//                per clock, start/busy/done handshake, saturating to all-9s
//                with a sticky overflow flag. Optional macro
//                LEADING_ZERO_BLANK_EN adds a registered leading-zero blank
//                vector alongside bcd.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_BCD_W-1:0] c_SAT     = {DIGITS{4'h9}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LD  = c_CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_sticky;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_overflow;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_scratch_next;
    logic                 w_carry;
    logic                 w_ovf_final;

    // Add-3 correction on every digit in parallel before the shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] w_dig;
            assign w_dig            = r_scratch[4*gi +: 4];
            assign w_adj[4*gi +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
        end
    endgenerate

    // Shift {scratch, shift} left by one; the bit leaving scratch is overflow
    assign w_scratch_next = {w_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_carry        = w_adj[c_BCD_W-1];
    assign w_ovf_final    = r_ovf_sticky | w_carry;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]    r_blank;
    logic [DIGITS-1:0]    w_blank_next;

    // A digit blanks when it and every higher digit are zero; digit 0 never blanks
    assign w_blank_next[0] = 1'b0;
    generate
        for (genvar gb = 1; gb < DIGITS; gb++) begin : g_blank
            if (gb == DIGITS - 1) begin : g_top
                assign w_blank_next[gb] = (w_scratch_next[4*gb +: 4] == 4'd0);
            end else begin : g_mid
                assign w_blank_next[gb] = (w_scratch_next[4*gb +: 4] == 4'd0) &
                                          w_blank_next[gb+1];
            end
        end
    endgenerate

    assign bus.blank = r_blank;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept start only while idle, leave SHIFT on the last bit
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shift, result publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_scratch    <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_overflow   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift      <= bus.num;
                r_scratch    <= '0;
                r_ovf_sticky <= 1'b0;
                r_cnt        <= c_CNT_LD;
                r_busy       <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
                r_scratch    <= w_scratch_next;
                r_ovf_sticky <= w_ovf_final;
                r_cnt        <= r_cnt - c_CNT_ONE;
                if (w_last) begin
                    r_bcd      <= w_ovf_final ? c_SAT : w_scratch_next;
                    r_overflow <= w_ovf_final;
`ifdef LEADING_ZERO_BLANK_EN
                    r_blank    <= w_ovf_final ? '0 : w_blank_next;
`endif
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. Expected results are
//                queued at start and compared when done pulses. A second
//                7-bit instance exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus  ();
    bin_to_bcd_seq_if #(.WIDTH(7),     .DIGITS(DIGITS)) bus7 ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bin_to_bcd_seq #(.WIDTH(7), .DIGITS(DIGITS)) u_dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus7)
    );

    typedef struct packed {
        logic       ovf;
        logic [7:0] bcd;
        logic [1:0] blank;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: decimal digits by division, saturate above 99
    function automatic exp_t model(input int n);
        exp_t e;
        e.ovf = (n > 99);
        if (e.ovf) begin
            e.bcd   = 8'h99;
            e.blank = 2'b00;
        end else begin
            e.bcd   = {4'(n / 10), 4'(n % 10)};
            e.blank = {((n / 10) == 0), 1'b0};
        end
        return e;
    endfunction

    // Scoreboard: each done pops one expected result
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            chk("busy_done_overlap", {31'd0, bus.busy}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, bus.done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bcd", {24'd0, bus.bcd}, {24'd0, mon_e.bcd});
                chk("overflow", {31'd0, bus.overflow}, {31'd0, mon_e.ovf});
`ifdef LEADING_ZERO_BLANK_EN
                chk("blank", {30'd0, bus.blank}, {30'd0, mon_e.blank});
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic start_conv(input int n, input bit push);
        bus.start = 1'b1;
        bus.num   = WIDTH'(n);
        if (push) exp_q.push_back(model(n));
        @(negedge clk);
        bus.start = 1'b0;
        bus.num   = WIDTH'($urandom);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        while (!bus.done && lat < 30) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) chk("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic run(input int n);
        int lat, bc;
        start_conv(n, 1'b1);
        wait_done(lat, bc);
        chk("latency", lat, WIDTH);
        chk("busy_cycles", bc, WIDTH);
        @(negedge clk);
    endtask

    task automatic run7(input int n, input logic [7:0] ebcd, input logic eovf);
        int lim;
        bus7.start = 1'b1;
        bus7.num   = 7'(n);
        @(negedge clk);
        bus7.start = 1'b0;
        lim = 0;
        while (!bus7.done && lim < 30) begin
            @(negedge clk);
            lim++;
        end
        chk("w7_done", {31'd0, bus7.done}, 32'd1);
        chk("w7_bcd", {24'd0, bus7.bcd}, {24'd0, ebcd});
        chk("w7_overflow", {31'd0, bus7.overflow}, {31'd0, eovf});
`ifdef LEADING_ZERO_BLANK_EN
        chk("w7_blank", {30'd0, bus7.blank}, 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, bc, d0;
        bus.start  = 1'b0;
        bus.num    = '0;
        bus7.start = 1'b0;
        bus7.num   = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_bcd", {24'd0, bus.bcd}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("rst_blank", {30'd0, bus.blank}, 32'd0);
`endif

        // Basic conversions
        run(63);
        run(9);
        run(0);
        run(10);

        // Saturation on a 7-bit instance, then recovery
        run7(127, 8'h99, 1'b1);
        run7(42, 8'h42, 1'b0);

        // start during busy is ignored
        d0 = done_cnt;
        start_conv(25, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = WIDTH'(50);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bc);
        repeat (10) @(negedge clk);
        chk("ignored_start_dones", done_cnt - d0, 1);

        // start in the done cycle is accepted
        start_conv(25, 1'b1);
        wait_done(lat, bc);
        start_conv(50, 1'b1);
        wait_done(lat, bc);
        chk("b2b_latency", lat, WIDTH);
        @(negedge clk);

        // Reset mid-conversion
        run(33);
        start_conv(17, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_bcd", {24'd0, bus.bcd}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

        // Exhaustive sweep
        d0 = done_cnt;
        for (int n = 0; n < 64; n++) run(n);
        repeat (2) @(negedge clk);
        chk("sweep_dones", done_cnt - d0, 64);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
